// File: rtl/cpu_axi_pkg.sv
// Shared types and constants for the CPU-to-AXI bridge and its helpers.
package cpu_axi_pkg;

  // Bridge transaction sequencer states
  typedef enum logic [2:0] {
    IDLE,
    RD_AR,
    RD_R,
    WR_AW_W,
    WR_B,
    DONE
  } state_t;

  // Which core port owns the outstanding transaction
  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [3:0] ID_INST_DEF = 4'd0;
  localparam logic [3:0] ID_DATA_DEF = 4'd1;

  // SRAM-like size encodings (log2 of the byte count)
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/axi_strb_gen.sv
// Combinational byte-lane strobe generator for 32-bit single-beat writes.
// Also used by the cache write path, so keep it free of bridge state.
module axi_strb_gen
  import cpu_axi_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] strb
);

  // Shift a size-shaped lane mask to the addressed byte; words always use all lanes
  always_comb begin
    strb = 4'b1111;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << addr_lo;
      SIZE_HALF: strb = 4'b0011 << addr_lo;
      default:   strb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/cpu_axi_bridge.sv
// Bridges the core's instruction and data SRAM-like ports onto one AXI3
// master. One single-beat transaction in flight; data beats inst in arbitration.
module cpu_axi_bridge
  import cpu_axi_pkg::*;
#(
  parameter logic [3:0] ID_INST = ID_INST_DEF,
  parameter logic [3:0] ID_DATA = ID_DATA_DEF
) (
  input  logic        clk,
  input  logic        rst,
  // instruction port
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  // data port
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_t      state_reg, state_next;
  src_t        src_reg;
  logic        wr_reg;
  logic [1:0]  size_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic        aw_done_reg;
  logic        w_done_reg;

  // Responses are not checked and fetches never write; fold them away
  logic unused_inputs;
  assign unused_inputs = ^{inst_wr, inst_wdata, rid, rresp, rlast, bid, bresp};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Capture the winning request in IDLE; data port has priority
  always_ff @(posedge clk) begin
    if (rst) begin
      src_reg   <= SRC_INST;
      wr_reg    <= 1'b0;
      size_reg  <= SIZE_BYTE;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else if (state_reg == IDLE) begin
      if (data_req) begin
        src_reg   <= SRC_DATA;
        wr_reg    <= data_wr;
        size_reg  <= data_size;
        addr_reg  <= data_addr;
        wdata_reg <= data_wdata;
      end else if (inst_req) begin
        src_reg   <= SRC_INST;
        wr_reg    <= 1'b0;
        size_reg  <= inst_size;
        addr_reg  <= inst_addr;
      end
    end
  end

  // Hold returned read data for the DONE pulse and afterwards
  always_ff @(posedge clk) begin
    if (rst)                                rdata_reg <= '0;
    else if (state_reg == RD_R && rvalid)   rdata_reg <= rdata;
  end

  // AW and W channels complete independently; remember which already handshook
  always_ff @(posedge clk) begin
    if (rst || state_reg != WR_AW_W) begin
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      if (awvalid && awready) aw_done_reg <= 1'b1;
      if (wvalid && wready)   w_done_reg  <= 1'b1;
    end
  end

  // Next-state logic and per-state handshake outputs
  always_comb begin
    state_next   = state_reg;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (data_req) begin
          data_addr_ok = 1'b1;
          state_next   = data_wr ? WR_AW_W : RD_AR;
        end else if (inst_req) begin
          inst_addr_ok = 1'b1;
          state_next   = RD_AR;
        end
      end
      RD_AR: begin
        arvalid = 1'b1;
        if (arready) state_next = RD_R;
      end
      RD_R: begin
        rready = 1'b1;
        if (rvalid) state_next = DONE;
      end
      WR_AW_W: begin
        awvalid = !aw_done_reg;
        wvalid  = !w_done_reg;
        if ((aw_done_reg || awready) && (w_done_reg || wready)) state_next = WR_B;
      end
      WR_B: begin
        bready = 1'b1;
        if (bvalid) state_next = DONE;
      end
      DONE: begin
        inst_data_ok = (src_reg == SRC_INST);
        data_data_ok = (src_reg == SRC_DATA);
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  axi_strb_gen u_strb (
    .size    (size_reg),
    .addr_lo (addr_reg[1:0]),
    .strb    (wstrb)
  );

  assign arid    = (src_reg == SRC_DATA) ? ID_DATA : ID_INST;
  assign araddr  = addr_reg;
  assign arlen   = 4'd0;
  assign arsize  = {1'b0, size_reg};
  assign arburst = BURST_INCR;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = ID_DATA;
  assign awaddr  = addr_reg;
  assign awlen   = 4'd0;
  assign awsize  = {1'b0, size_reg};
  assign awburst = BURST_INCR;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid     = ID_DATA;
  assign wdata   = wdata_reg;
  assign wlast   = 1'b1;

  assign inst_rdata = rdata_reg;
  assign data_rdata = rdata_reg;

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Self-checking bench for cpu_axi_bridge: table of single transactions against
// a wait-state-programmable AXI slave, plus arbitration and reset sequences.
module tb_cpu_axi_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inst_req = 1'b0, inst_wr = 1'b0;
  logic [1:0]  inst_size = 2'd2;
  logic [31:0] inst_addr = '0, inst_wdata = '0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 1'b0, data_wr = 1'b0;
  logic [1:0]  data_size = 2'd2;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb;
  logic [31:0] araddr, awaddr, wdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock;
  logic        arvalid, rready, awvalid, wvalid, wlast, bready;
  logic        arready = 1'b0, rvalid = 1'b0, rlast = 1'b1, awready = 1'b0;
  logic        wready = 1'b0, bvalid = 1'b0;
  logic [3:0]  rid = '0, bid = '0;
  logic [1:0]  rresp = '0, bresp = '0;
  logic [31:0] rdata = '0;

  always #5 clk = ~clk;

  cpu_axi_bridge dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // ---------------- AXI slave: programmable wait states ----------------
  int ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
  logic [31:0] resp_word = '0;

  always @(posedge clk) begin
    #1;
    if (arvalid === 1'b1) begin arready = (ar_cnt >= ar_wait); ar_cnt++; end
    else begin arready = 1'b0; ar_cnt = 0; end
    if (rready === 1'b1) begin rvalid = (r_cnt >= r_wait); r_cnt++; end
    else begin rvalid = 1'b0; r_cnt = 0; end
    if (awvalid === 1'b1) begin awready = (aw_cnt >= aw_wait); aw_cnt++; end
    else begin awready = 1'b0; aw_cnt = 0; end
    if (wvalid === 1'b1) begin wready = (w_cnt >= w_wait); w_cnt++; end
    else begin wready = 1'b0; w_cnt = 0; end
    if (bready === 1'b1) begin bvalid = (b_cnt >= b_wait); b_cnt++; end
    else begin bvalid = 1'b0; b_cnt = 0; end
    rdata = resp_word;
  end

  // ---------------- handshake observer and scoreboard ----------------
  typedef struct {
    bit          src;    // 1 = data port
    bit          wr;
    logic [31:0] rdata;
    int          t;      // cycle of addr_ok
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_ar = 0, n_aw = 0, n_w = 0, n_b = 0;
  logic [3:0]  cap_arid, cap_arlen, cap_awid, cap_wid, cap_wstrb;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [2:0]  cap_arsize, cap_awsize;
  logic [1:0]  cap_arburst;
  logic        cap_wlast;

  always @(negedge clk) begin
    if (arvalid === 1'b1 && arready) begin
      n_ar++; cap_arid = arid; cap_araddr = araddr; cap_arsize = arsize;
      cap_arlen = arlen; cap_arburst = arburst;
    end
    if (awvalid === 1'b1 && awready) begin
      n_aw++; cap_awid = awid; cap_awaddr = awaddr; cap_awsize = awsize;
    end
    if (wvalid === 1'b1 && wready) begin
      n_w++; cap_wid = wid; cap_wdata = wdata; cap_wstrb = wstrb; cap_wlast = wlast;
    end
    if (bready === 1'b1 && bvalid) n_b++;
    if (inst_data_ok === 1'b1 || data_data_ok === 1'b1) begin
      chk("data_ok_onehot", {31'd0, inst_data_ok & data_data_ok}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_data_ok", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data_ok_port", {31'd0, data_data_ok}, {31'd0, e.src});
        chk("latency", cyc - e.t, e.lat);
        if (!e.wr) chk("rdata", e.src ? data_rdata : inst_rdata, e.rdata);
      end
    end
  end

  task automatic wait_empty();
    for (int i = 0; i < 100; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("sb_drain", sb.size(), 0);
  endtask

  // ---------------- table-driven single transactions ----------------
  typedef struct {
    bit          is_data;
    bit          wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] resp;
    int          arw, rw, aww, ww, bw;
    int          lat;
    logic [3:0]  strb;
  } vec_t;
  vec_t vecs[11];

  task automatic run_vec(input int idx, input vec_t v);
    ar_wait = v.arw; r_wait = v.rw; aw_wait = v.aww; w_wait = v.ww; b_wait = v.bw;
    resp_word = v.resp;
    n_ar = 0; n_aw = 0; n_w = 0; n_b = 0;
    @(posedge clk); #1;
    if (v.is_data) begin
      data_req = 1'b1; data_wr = v.wr; data_size = v.size;
      data_addr = v.addr; data_wdata = v.wd;
    end else begin
      inst_req = 1'b1; inst_size = v.size; inst_addr = v.addr;
    end
    @(negedge clk);
    chk($sformatf("v%0d_addr_ok", idx), {30'd0, inst_addr_ok, data_addr_ok},
        v.is_data ? 32'd1 : 32'd2);
    sb.push_back(exp_t'{v.is_data, v.wr, v.resp, cyc, v.lat});
    @(posedge clk); #1;
    data_req = 1'b0; inst_req = 1'b0;
    wait_empty();
    if (!v.wr) begin
      chk($sformatf("v%0d_n_ar", idx), n_ar, 1);
      chk($sformatf("v%0d_arid", idx), cap_arid, v.is_data ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_araddr", idx), cap_araddr, v.addr);
      chk($sformatf("v%0d_arsize", idx), cap_arsize, {30'd0, v.size});
      chk($sformatf("v%0d_arlen_burst", idx), {cap_arlen, cap_arburst}, 32'b00_0001);
    end else begin
      chk($sformatf("v%0d_n_aw_w_b", idx), {n_aw[7:0], n_w[7:0], n_b[7:0]}, 32'h010101);
      chk($sformatf("v%0d_awaddr", idx), cap_awaddr, v.addr);
      chk($sformatf("v%0d_awsize", idx), cap_awsize, {30'd0, v.size});
      chk($sformatf("v%0d_wstrb", idx), cap_wstrb, v.strb);
      chk($sformatf("v%0d_wdata", idx), cap_wdata, v.wd);
      chk($sformatf("v%0d_ids_wlast", idx), {cap_awid, cap_wid, 3'd0, cap_wlast}, 32'h111);
    end
    $display("[TB] vector %0d %s addr=%h done", idx, v.wr ? "write" : "read", v.addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t0;
    bit   found;

    //          data wr size addr          wdata         resp         ar r aw w b lat strb
    vecs[0]  = '{0, 0, 2'd2, 32'hBFC00000, 32'h0,        32'h3C1D0001, 0, 0, 0, 0, 0, 3, 4'b1111};
    vecs[1]  = '{1, 0, 2'd2, 32'h80001000, 32'h0,        32'h12345678, 0, 0, 0, 0, 0, 3, 4'b1111};
    vecs[2]  = '{1, 1, 2'd0, 32'h80000003, 32'hAB000000, 32'h0,        0, 0, 0, 0, 0, 3, 4'b1000};
    vecs[3]  = '{1, 1, 2'd1, 32'h80000002, 32'hCDEF0000, 32'h0,        0, 0, 0, 0, 0, 3, 4'b1100};
    vecs[4]  = '{1, 1, 2'd2, 32'h80000010, 32'hDEADBEEF, 32'h0,        0, 0, 0, 0, 0, 3, 4'b1111};
    vecs[5]  = '{1, 1, 2'd0, 32'h80000001, 32'h0000AB00, 32'h0,        0, 0, 0, 0, 0, 3, 4'b0010};
    vecs[6]  = '{1, 0, 2'd2, 32'h80002000, 32'h0,        32'hCAFEF00D, 3, 2, 0, 0, 0, 8, 4'b1111};
    vecs[7]  = '{1, 1, 2'd2, 32'h80000020, 32'h11223344, 32'h0,        0, 0, 2, 0, 0, 5, 4'b1111};
    vecs[8]  = '{1, 1, 2'd1, 32'h80000040, 32'h00005566, 32'h0,        0, 0, 0, 3, 1, 7, 4'b0011};
    vecs[9]  = '{0, 0, 2'd2, 32'hBFC00004, 32'h0,        32'h24080002, 1, 0, 0, 0, 0, 4, 4'b1111};
    vecs[10] = '{1, 0, 2'd0, 32'h80000005, 32'h0,        32'h000000AA, 0, 1, 0, 0, 0, 4, 4'b0010};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valids", {25'd0, arvalid, awvalid, wvalid, rready, bready, inst_data_ok, data_data_ok}, 32'd0);
    chk("reset_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    chk("reset_inst_rdata", inst_rdata, 32'd0);
    chk("reset_data_rdata", data_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Arbitration: both ports request; data wins, inst waits until after DONE
    ar_wait = 3; r_wait = 2; resp_word = 32'h0BADCAFE;
    n_ar = 0;
    @(posedge clk); #1;
    inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'hBFC00008;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80001000;
    @(negedge clk);
    chk("arb_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("arb_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    t0 = cyc;
    sb.push_back(exp_t'{1'b1, 1'b0, 32'h0BADCAFE, cyc, 8});
    @(posedge clk); #1;
    data_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (inst_addr_ok === 1'b1) begin found = 1'b1; break; end
    end
    chk("arb_inst_ok_seen", {31'd0, found}, 32'd1);
    chk("arb_inst_ok_cycle", cyc - t0, 32'd9);
    if (found) begin
      ar_wait = 0; r_wait = 0; resp_word = 32'h3C1D0002;
      sb.push_back(exp_t'{1'b0, 1'b0, 32'h3C1D0002, cyc, 3});
    end
    @(posedge clk); #1;
    inst_req = 1'b0;
    wait_empty();
    chk("arb_n_ar", n_ar, 2);
    chk("arb_last_arid", cap_arid, 32'd0);
    chk("arb_last_araddr", cap_araddr, 32'hBFC00008);
    $display("[TB] arbitration sequence done");

    // Reset while waiting in RD_R discards the request
    r_wait = 100; ar_wait = 0; resp_word = 32'h55555555;
    @(posedge clk); #1;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h80003000;
    @(negedge clk);
    chk("rst_seq_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    @(posedge clk); #1;
    data_req = 1'b0;
    @(negedge clk);
    chk("rst_seq_arvalid", {31'd0, arvalid}, 32'd1);
    @(negedge clk);
    chk("rst_seq_rready_before", {31'd0, rready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rst_seq_rready_after", {29'd0, rready, arvalid, data_data_ok}, 32'd0);
    chk("rst_seq_rdata_cleared", data_rdata, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_seq_idle_quiet", {28'd0, rready, arvalid, awvalid, data_data_ok}, 32'd0);
    $display("[TB] reset-in-RD_R sequence done");
    run_vec(11, '{1, 0, 2'd2, 32'h80003000, 32'h0, 32'h600DF00D, 0, 0, 0, 0, 0, 3, 4'b1111});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_axi_bridge.md
# cpu_axi_bridge

Converts the core's two SRAM-like request ports (instruction fetch and data access) into a single AXI3 master port carrying single-beat transactions. Sits directly downstream of the CPU top: it consumes its instruction and data memory requests, returns read data with a request/address-ok/data-ok handshake, and drives the SoC interconnect. Exactly one transaction is outstanding at a time. Data requests win arbitration over instruction fetches.

## Interface
Parameters:
- ID_INST, 4'd0, ARID used for instruction reads
- ID_DATA, 4'd1, ARID/AWID used for data accesses

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- inst_req / inst_wr / inst_size  in  1/1/2  fetch request; wr always 0; size 2 = word
- inst_addr / inst_wdata  in  32/32  fetch address; wdata ignored
- inst_addr_ok / inst_data_ok  out  1/1  request accepted / read data valid (1-cycle pulses)
- inst_rdata  out  32  fetched word
- data_req / data_wr / data_size  in  1/1/2  data request; size 0 = byte, 1 = half, 2 = word
- data_addr / data_wdata  in  32/32  byte address; store data already lane-aligned
- data_addr_ok / data_data_ok / data_rdata  out  1/1/32  same meaning as the inst_* versions
- arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/4/3/2/1  AXI read address; arready in 1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI read data; rready out 1
- awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/4/3/2/1  AXI write address; awready in 1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI write data; wready in 1
- bid/bresp/bvalid  in  4/2/1  AXI write response; bready out 1
- arlock/arcache/arprot, awlock/awcache/awprot  out  2/4/3  tied to 0

## Operation
- FSM states: IDLE, RD_AR, RD_R, WR_AW_W, WR_B, DONE.
- IDLE: if data_req=1, pulse data_addr_ok and latch {src=data, wr, size, addr, wdata}. Else if inst_req=1, pulse inst_addr_ok and latch {src=inst}. Next state is RD_AR for a read, WR_AW_W for a write.
- RD_AR: arvalid=1 with latched address; arid from src; arlen=0, arsize={1'b0,size}, arburst=2'b01. When arvalid & arready, go to RD_R.
- RD_R: rready=1. On rvalid, latch rdata and go to DONE. rresp and rid are ignored.
- WR_AW_W: awvalid and wvalid both start at 1. Each one drops independently after its own handshake, tracked by flags aw_done and w_done. When both are done (including the same cycle), go to WR_B. wlast=1, wid=awid=ID_DATA.
- wstrb by size: size 0 → 4'b0001<<addr[1:0]; size 1 → 4'b0011<<addr[1:0]; size 2 → 4'b1111.
- WR_B: bready=1. On bvalid, go to DONE.
- DONE: pulse data_ok for one cycle on the latched source; *_rdata = latched rdata (undefined for writes). Next state is IDLE.
- addr_ok is only ever asserted in IDLE. A request that is held while the bridge is busy waits with no side effect.
- Reset mid-transaction: state returns to IDLE, all valids/readies drop, and the latched request is discarded. The interconnect is reset by the same rst.

## Timing
- Reset values: all *_addr_ok, *_data_ok, arvalid, awvalid, wvalid, rready, bready = 0; rdata outputs = 0; state = IDLE; aw_done = w_done = 0.
- addr_ok is combinational from req in IDLE, in the same cycle as req.
- Read latency with a zero-wait slave: addr_ok at T, arvalid at T+1 (arready same cycle), rvalid at T+2, data_ok at T+3.
- Write latency with a zero-wait slave: addr_ok at T, AW and W handshakes at T+1, bvalid at T+2, data_ok at T+3.
- Each extra slave wait cycle adds one cycle of latency. The earliest next addr_ok is the cycle after DONE.

## Structure
- Shared package cpu_axi_pkg holds: the state enum, BURST_INCR = 2'b01, ID_INST/ID_DATA defaults, and size encodings.
- One natural sub-module: axi_strb_gen, a combinational map from (size, addr[1:0]) to wstrb, reused by the later cache write path.

## Test plan
- Inst read 0xBFC00000, slave returns 0x3C1D0001 with zero waits → inst_addr_ok at T, arid=0, inst_data_ok at T+3, inst_rdata=0x3C1D0001.
- inst_req and data_req (read 0x80001000) both high in IDLE → only data_addr_ok; data read completes first, then inst_addr_ok is pulsed in the cycle after DONE.
- Byte store size 0, addr 0x80000003, wdata 0xAB000000 → awaddr 0x80000003, wstrb 4'b1000, awsize 0, data_data_ok after bvalid.
- Slave asserts wready 2 cycles before awready → wvalid drops after its handshake, awvalid is held, and WR_B is entered only after awready.
- Read with arready delayed 3 cycles and rvalid delayed 2 cycles → data_ok at T+8, no extra addr_ok pulses while inst_req is held.
- rst asserted in RD_R → next cycle: IDLE, rready=0, no data_ok. A new request after reset completes normally.
